// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - RV32I ALU-subset decoder with RAW scoreboard and single-entry issue stage

package decode_issue_pkg;
    typedef enum logic [4:0] {
        I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_SRL, I_SRA, I_OR, I_AND,
        I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI, I_SLLI, I_SRLI, I_SRAI,
        I_LUI, I_AUIPC
    } instr_t;

    typedef enum logic [1:0] {TYPE_R, TYPE_I, TYPE_U} instr_type_t;
endpackage

module decode_issue
    import decode_issue_pkg::*;
#(
    parameter int wd_regs_p = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_fetch_valid,
    output logic                 o_fetch_ready,
    input  logic [31:0]          i_fetch_instr,
    input  logic [wd_regs_p-1:0] i_fetch_pc,
    input  logic                 i_flush,
    output logic [4:0]           o_rs1_addr,
    output logic [4:0]           o_rs2_addr,
    input  logic [wd_regs_p-1:0] i_rs1_data,
    input  logic [wd_regs_p-1:0] i_rs2_data,
    input  logic                 i_wb_valid,
    input  logic [4:0]           i_wb_rd,
    output logic                 o_issue_valid,
    output logic [wd_regs_p-1:0] o_pc,
    output logic [wd_regs_p-1:0] o_arg1,
    output logic [wd_regs_p-1:0] o_arg2,
    output instr_t               o_instr,
    output instr_type_t          o_instr_type,
    output logic [4:0]           o_rd,
    output logic                 o_illegal
);
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic {RUN, STALL} state_t;

    state_t                state, state_d;
    logic                  hold_valid;
    logic [31:0]           hold_word;
    logic [wd_regs_p-1:0]  hold_pc;
    logic [31:0]           pending, pending_d;
    instr_t                dec_instr;
    instr_type_t           dec_type;
    logic                  dec_legal;
    logic [wd_regs_p-1:0]  arg1_d, arg2_d;
    logic                  hazard, issue_fire, illegal_drop, fetch_fire;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd;

    assign opcode     = hold_word[6:0];
    assign funct3     = hold_word[14:12];
    assign funct7     = hold_word[31:25];
    assign rd         = hold_word[11:7];
    assign o_rs1_addr = hold_word[19:15];
    assign o_rs2_addr = hold_word[24:20];

    // Decode the held word into operation, format and legality
    always_comb begin
        dec_instr = I_ADD;
        dec_type  = TYPE_R;
        dec_legal = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec_type = TYPE_R;
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_ZERO) begin
                            dec_instr = I_ADD; dec_legal = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            dec_instr = I_SUB; dec_legal = 1'b1;
                        end
                    end
                    3'b001: begin dec_instr = I_SLL;  dec_legal = (funct7 == F7_ZERO); end
                    3'b010: begin dec_instr = I_SLT;  dec_legal = (funct7 == F7_ZERO); end
                    3'b011: begin dec_instr = I_SLTU; dec_legal = (funct7 == F7_ZERO); end
                    3'b100: begin dec_instr = I_XOR;  dec_legal = (funct7 == F7_ZERO); end
                    3'b101: begin
                        if (funct7 == F7_ZERO) begin
                            dec_instr = I_SRL; dec_legal = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            dec_instr = I_SRA; dec_legal = 1'b1;
                        end
                    end
                    3'b110: begin dec_instr = I_OR;  dec_legal = (funct7 == F7_ZERO); end
                    default: begin dec_instr = I_AND; dec_legal = (funct7 == F7_ZERO); end
                endcase
            end
            7'b0010011: begin
                dec_type = TYPE_I;
                case (funct3)
                    3'b000: begin dec_instr = I_ADDI;  dec_legal = 1'b1; end
                    3'b001: begin dec_instr = I_SLLI;  dec_legal = (funct7 == F7_ZERO); end
                    3'b010: begin dec_instr = I_SLTI;  dec_legal = 1'b1; end
                    3'b011: begin dec_instr = I_SLTIU; dec_legal = 1'b1; end
                    3'b100: begin dec_instr = I_XORI;  dec_legal = 1'b1; end
                    3'b101: begin
                        if (funct7 == F7_ZERO) begin
                            dec_instr = I_SRLI; dec_legal = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            dec_instr = I_SRAI; dec_legal = 1'b1;
                        end
                    end
                    3'b110: begin dec_instr = I_ORI;  dec_legal = 1'b1; end
                    default: begin dec_instr = I_ANDI; dec_legal = 1'b1; end
                endcase
            end
            7'b0110111: begin dec_type = TYPE_U; dec_instr = I_LUI;   dec_legal = 1'b1; end
            7'b0010111: begin dec_type = TYPE_U; dec_instr = I_AUIPC; dec_legal = 1'b1; end
            default: ;
        endcase
    end

    // Operand select; immediates are passed raw and the ALU extends them
    always_comb begin
        arg1_d = '0;
        arg2_d = '0;
        case (dec_type)
            TYPE_R: begin arg1_d = i_rs1_data; arg2_d = i_rs2_data; end
            TYPE_I: begin
                arg1_d = i_rs1_data;
                arg2_d = {{(wd_regs_p-12){1'b0}}, hold_word[31:20]};
            end
            TYPE_U: arg2_d = {{(wd_regs_p-20){1'b0}}, hold_word[31:12]};
            default: ;
        endcase
    end

    assign hazard = dec_legal &&
                    (((dec_type == TYPE_R || dec_type == TYPE_I) && pending[o_rs1_addr]) ||
                     ((dec_type == TYPE_R) && pending[o_rs2_addr]));

    // Stall FSM: next state plus issue/drop/ready decisions
    always_comb begin
        state_d      = state;
        issue_fire   = 1'b0;
        illegal_drop = hold_valid && !dec_legal && !i_flush;
        case (state)
            RUN: begin
                issue_fire = hold_valid && dec_legal && !hazard && !i_flush;
                if (hold_valid && dec_legal && hazard && !i_flush)
                    state_d = STALL;
            end
            default: begin
                issue_fire = hold_valid && dec_legal && !hazard && !i_flush;
                if (i_flush || !hazard)
                    state_d = RUN;
            end
        endcase
        o_fetch_ready = rst_n && !i_flush && (!hold_valid || issue_fire || illegal_drop);
    end

    assign fetch_fire = i_fetch_valid && o_fetch_ready;

    // Scoreboard update: writeback clears, issue sets (set wins), x0 never pending
    always_comb begin
        pending_d = pending;
        if (i_wb_valid)
            pending_d[i_wb_rd] = 1'b0;
        if (issue_fire && rd != 5'd0)
            pending_d[rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // State, hold register and scoreboard
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            hold_valid <= 1'b0;
            hold_word  <= '0;
            hold_pc    <= '0;
            pending    <= '0;
        end else begin
            state   <= state_d;
            pending <= pending_d;
            if (i_flush)
                hold_valid <= 1'b0;
            else if (fetch_fire) begin
                hold_valid <= 1'b1;
                hold_word  <= i_fetch_instr;
                hold_pc    <= i_fetch_pc;
            end else if (issue_fire || illegal_drop)
                hold_valid <= 1'b0;
        end
    end

    // Registered issue outputs, valid for exactly one cycle per instruction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_issue_valid <= 1'b0;
            o_illegal     <= 1'b0;
            o_pc          <= '0;
            o_arg1        <= '0;
            o_arg2        <= '0;
            o_rd          <= '0;
            o_instr       <= I_ADD;
            o_instr_type  <= TYPE_R;
        end else begin
            o_issue_valid <= issue_fire;
            o_illegal     <= illegal_drop;
            if (issue_fire) begin
                o_pc         <= hold_pc;
                o_arg1       <= arg1_d;
                o_arg2       <= arg2_d;
                o_rd         <= rd;
                o_instr      <= dec_instr;
                o_instr_type <= dec_type;
            end
        end
    end
endmodule
